// File: rtl/atom_sched_pkg.sv
// Shared types for the 2R2W atom scheduler.
package atom_sched_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } sched_state_e;

  // Tag index is sized for the largest supported requester count.
  localparam int unsigned MAXREQ = 16;
  localparam int unsigned REQIDX = $clog2(MAXREQ);

  typedef struct packed {
    logic              vld;
    logic [REQIDX-1:0] idx;
  } rd_tag_t;

endpackage

// File: rtl/rr_pick2.sv
// Round-robin picker granting up to two requesters per cycle. With ADR_MASK set, the second
// winner must carry a different address than the first.
module rr_pick2 #(
  parameter int unsigned N        = 4,
  parameter int unsigned AW       = 3,
  parameter bit          ADR_MASK = 1'b0
) (
  input  logic [N-1:0]         req,
  input  logic [N*AW-1:0]      adr,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic                 vld_0,
  output logic [$clog2(N)-1:0] idx_0,
  output logic [AW-1:0]        adr_0,
  output logic                 vld_1,
  output logic [$clog2(N)-1:0] idx_1,
  output logic [AW-1:0]        adr_1,
  output logic [$clog2(N)-1:0] ptr_nxt
);

  localparam int unsigned IW = $clog2(N);

  // Scan from ptr with wrap; first hit is winner 0, next eligible hit is winner 1.
  always_comb begin
    int unsigned j;
    logic [AW-1:0] a;
    j     = 0;
    a     = '0;
    gnt   = '0;
    vld_0 = 1'b0;
    idx_0 = '0;
    adr_0 = '0;
    vld_1 = 1'b0;
    idx_1 = '0;
    adr_1 = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      a = adr[j*AW +: AW];
      if (req[j]) begin
        if (!vld_0) begin
          vld_0  = 1'b1;
          idx_0  = IW'(j);
          adr_0  = a;
          gnt[j] = 1'b1;
        end else if (!vld_1 && !(ADR_MASK && (a == adr_0))) begin
          vld_1  = 1'b1;
          idx_1  = IW'(j);
          adr_1  = a;
          gnt[j] = 1'b1;
        end
      end
    end
  end

  // Pointer moves one past the last granted index; holds when nothing is granted.
  always_comb begin
    logic [IW-1:0] last;
    last = vld_1 ? idx_1 : idx_0;
    if (!vld_0) begin
      ptr_nxt = ptr;
    end else if (32'(last) == N - 1) begin
      ptr_nxt = '0;
    end else begin
      ptr_nxt = last + IW'(1);
    end
  end

endmodule

// File: rtl/atom_2r2w_sched.sv
// Scheduler sharing a 2R2W memory atom among NUMREQ read and NUMREQ write clients. Runs the
// optional post-reset init sweep and holds all clients off until it completes.
module atom_2r2w_sched
  import atom_sched_pkg::*;
#(
  parameter int unsigned NUMREQ     = 4,
  parameter int unsigned NUMADDR    = 8,
  parameter int unsigned BITADDR    = 3,
  parameter int unsigned BITDATA    = 1,
  parameter int unsigned SRAM_DELAY = 0,
  parameter int unsigned RSTINIT    = 0,
  parameter int unsigned RSTSTRT    = 0,
  parameter int unsigned RSTINCR    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ready,
  input  logic [NUMREQ-1:0]         rd_req,
  input  logic [NUMREQ*BITADDR-1:0] rd_adr,
  output logic [NUMREQ-1:0]         rd_gnt,
  output logic [NUMREQ-1:0]         rd_vld,
  output logic [BITDATA-1:0]        rd_dout,
  input  logic [NUMREQ-1:0]         wr_req,
  input  logic [NUMREQ*BITADDR-1:0] wr_adr,
  input  logic [NUMREQ*BITDATA-1:0] wr_din,
  output logic [NUMREQ-1:0]         wr_gnt,
  output logic                      read_0,
  output logic [BITADDR-1:0]        rd_adr_0,
  output logic                      read_1,
  output logic [BITADDR-1:0]        rd_adr_1,
  input  logic [BITDATA-1:0]        rd_dout_0,
  input  logic [BITDATA-1:0]        rd_dout_1,
  output logic                      write_2,
  output logic [BITADDR-1:0]        wr_adr_2,
  output logic [BITDATA-1:0]        wr_din_2,
  output logic                      write_3,
  output logic [BITADDR-1:0]        wr_adr_3,
  output logic [BITDATA-1:0]        wr_din_3
);

  localparam int unsigned IW = $clog2(NUMREQ);
  localparam int unsigned CW = $clog2(NUMADDR + 1);

  sched_state_e  state_q, state_d;
  logic          sweep_q, sweep_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic          run;

  logic                rp_vld_0, rp_vld_1, wp_vld_0, wp_vld_1;
  logic [IW-1:0]       rp_idx_0, rp_idx_1, wp_idx_0, wp_idx_1;
  logic [BITADDR-1:0]  wp_adr_0, wp_adr_1;
  rd_tag_t             tag_in_0, tag_in_1, tag_out_0, tag_out_1;

  assign run   = (state_q == RUN);
  assign ready = run;

  function automatic logic [BITDATA-1:0] init_val(input int unsigned a);
    return BITDATA'(RSTSTRT + a * RSTINCR);
  endfunction

  rr_pick2 #(
    .N        (NUMREQ),
    .AW       (BITADDR),
    .ADR_MASK (1'b0)
  ) u_rd_pick (
    .req     (rd_req & {NUMREQ{run}}),
    .adr     (rd_adr),
    .ptr     (rd_ptr_q),
    .gnt     (rd_gnt),
    .vld_0   (rp_vld_0),
    .idx_0   (rp_idx_0),
    .adr_0   (rd_adr_0),
    .vld_1   (rp_vld_1),
    .idx_1   (rp_idx_1),
    .adr_1   (rd_adr_1),
    .ptr_nxt (rd_ptr_d)
  );

  rr_pick2 #(
    .N        (NUMREQ),
    .AW       (BITADDR),
    .ADR_MASK (1'b1)
  ) u_wr_pick (
    .req     (wr_req & {NUMREQ{run}}),
    .adr     (wr_adr),
    .ptr     (wr_ptr_q),
    .gnt     (wr_gnt),
    .vld_0   (wp_vld_0),
    .idx_0   (wp_idx_0),
    .adr_0   (wp_adr_0),
    .vld_1   (wp_vld_1),
    .idx_1   (wp_idx_1),
    .adr_1   (wp_adr_1),
    .ptr_nxt (wr_ptr_d)
  );

  assign read_0 = rp_vld_0;
  assign read_1 = rp_vld_1;

  // Write ports: client winners in RUN, init sweep pairs (cnt, cnt+1) in INIT.
  always_comb begin
    write_2  = wp_vld_0;
    wr_adr_2 = wp_adr_0;
    wr_din_2 = '0;
    write_3  = wp_vld_1;
    wr_adr_3 = wp_adr_1;
    wr_din_3 = '0;
    for (int unsigned k = 0; k < NUMREQ; k++) begin
      if (wp_vld_0 && (wp_idx_0 == IW'(k))) wr_din_2 = wr_din[k*BITDATA +: BITDATA];
      if (wp_vld_1 && (wp_idx_1 == IW'(k))) wr_din_3 = wr_din[k*BITDATA +: BITDATA];
    end
    if (!run && sweep_q) begin
      write_2  = 1'b1;
      wr_adr_2 = BITADDR'(cnt_q);
      wr_din_2 = init_val(32'(cnt_q));
      write_3  = (32'(cnt_q) + 1 < NUMADDR);
      wr_adr_3 = BITADDR'(32'(cnt_q) + 1);
      wr_din_3 = write_3 ? init_val(32'(cnt_q) + 1) : '0;
    end
  end

  // The first INIT cycle after release is idle; the sweep then writes two words per cycle and
  // the FSM enters RUN after the cycle carrying the last word.
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      if (RSTINIT == 0) begin
        state_d = RUN;
      end else if (!sweep_q) begin
        sweep_d = 1'b1;
      end else if (32'(cnt_q) + 2 >= NUMADDR) begin
        state_d = RUN;
        sweep_d = 1'b0;
      end else begin
        cnt_d = cnt_q + CW'(2);
      end
    end
  end

  // FSM, sweep counter and round-robin pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      sweep_q  <= 1'b0;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sweep_q  <= sweep_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  assign tag_in_0 = {rp_vld_0, REQIDX'(rp_idx_0)};
  assign tag_in_1 = {rp_vld_1, REQIDX'(rp_idx_1)};

  if (SRAM_DELAY == 0) begin : g_nodly
    assign tag_out_0 = tag_in_0;
    assign tag_out_1 = tag_in_1;
  end else begin : g_dly
    rd_tag_t pipe_0_q [SRAM_DELAY];
    rd_tag_t pipe_1_q [SRAM_DELAY];

    // Tags travel alongside the atom's read latency; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int unsigned k = 0; k < SRAM_DELAY; k++) begin
          pipe_0_q[k] <= '0;
          pipe_1_q[k] <= '0;
        end
      end else begin
        pipe_0_q[0] <= tag_in_0;
        pipe_1_q[0] <= tag_in_1;
        for (int unsigned k = 1; k < SRAM_DELAY; k++) begin
          pipe_0_q[k] <= pipe_0_q[k-1];
          pipe_1_q[k] <= pipe_1_q[k-1];
        end
      end
    end

    assign tag_out_0 = pipe_0_q[SRAM_DELAY-1];
    assign tag_out_1 = pipe_1_q[SRAM_DELAY-1];
  end

  // Return path: flag the tagged requesters and steer atom data; port 0 wins the shared bus.
  always_comb begin
    rd_vld = '0;
    for (int unsigned k = 0; k < NUMREQ; k++) begin
      if (tag_out_0.vld && (tag_out_0.idx == REQIDX'(k))) rd_vld[k] = 1'b1;
      if (tag_out_1.vld && (tag_out_1.idx == REQIDX'(k))) rd_vld[k] = 1'b1;
    end
    if (tag_out_0.vld) begin
      rd_dout = rd_dout_0;
    end else if (tag_out_1.vld) begin
      rd_dout = rd_dout_1;
    end else begin
      rd_dout = '0;
    end
  end

endmodule
